// File: rtl/idct_round_sat_pipe_pkg.sv
// Shared types and constants for the IDCT round/saturate pipeline.
// Holds the rounding-mode encoding and the saturation-count width.
package idct_round_sat_pipe_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'd0,
    RND_HALF_UP   = 2'd1,
    RND_HALF_EVEN = 2'd2
  } rnd_mode_e;

  localparam int SAT_CNT_W = 16;

endpackage

// File: rtl/idct_round_sat_lane.sv
// One lane: arithmetic right shift, rounding, saturation to WOUT bits.
// Shift values above WIN-1 are clamped; mode 3 behaves as half-up.
module idct_round_sat_lane
  import idct_round_sat_pipe_pkg::*;
#(
  parameter int WIN  = 42,
  parameter int WOUT = 24,
  parameter int WSH  = 5
) (
  input  logic [WIN-1:0]  x,
  input  logic [WSH-1:0]  shift,
  input  logic [1:0]      mode,
  output logic [WOUT-1:0] y,
  output logic            sat
);

  localparam int SW = $clog2(WIN + 1);

  logic [SW-1:0]         s_eff;
  logic [SW-1:0]         s_m1;
  logic signed [WIN:0]   xe;
  logic signed [WIN:0]   q;
  logic signed [WIN:0]   ysum;
  logic [WIN:0]          lo_mask;
  logic [WIN-WOUT+1:0]   top;
  logic                  half;
  logic                  sticky;
  logic                  r;

  // Shift, pick the rounding increment, then clamp to the output range.
  always_comb begin
    y      = '0;
    sat    = 1'b0;
    r      = 1'b0;
    s_eff  = (32'(shift) > 32'(WIN - 1)) ? SW'(WIN - 1) : SW'(shift);
    s_m1   = s_eff - SW'(1);
    xe     = {x[WIN-1], x};
    q      = xe >>> s_eff;
    lo_mask = ~({(WIN+1){1'b1}} << s_m1);
    half   = (s_eff != '0) && xe[s_m1];
    sticky = |(xe & lo_mask);
    unique case (mode)
      RND_TRUNC:     r = 1'b0;
      RND_HALF_EVEN: r = half & (sticky | q[0]);
      default:       r = half;
    endcase
    ysum = q + {{WIN{1'b0}}, r};
    top  = ysum[WIN:WOUT-1];
    if ((&top) || (top == '0)) begin
      y = ysum[WOUT-1:0];
    end else if (ysum[WIN]) begin
      y   = {1'b1, {(WOUT-1){1'b0}}};
      sat = 1'b1;
    end else begin
      y   = {1'b0, {(WOUT-1){1'b1}}};
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/idct_round_sat_pipe.sv
// Round/saturate stream stage with output register plus skid buffer.
// Define IDCT_SAT_CNT_EN to build the per-frame saturation counter.
module idct_round_sat_pipe
  import idct_round_sat_pipe_pkg::*;
#(
  parameter int WIN       = 42,
  parameter int WOUT      = 24,
  parameter int WSH       = 5,
  parameter int SHIFT_DEF = 16
) (
  input  logic                 clk,
  input  logic                 rst_sync,
  input  logic                 sink_valid,
  output logic                 sink_ready,
  input  logic                 sink_sop,
  input  logic                 sink_eop,
  input  logic [1:0]           sink_error,
  input  logic [WIN-1:0]       sink_real,
  input  logic [WIN-1:0]       sink_imag,
  input  logic [WSH-1:0]       shift_in,
  input  logic [1:0]           rnd_mode,
  output logic                 source_valid,
  input  logic                 source_ready,
  output logic                 source_sop,
  output logic                 source_eop,
  output logic [1:0]           source_error,
  output logic [WOUT-1:0]      source_real,
  output logic [WOUT-1:0]      source_imag,
  output logic                 source_sat,
  output logic [SAT_CNT_W-1:0] sat_cnt,
  output logic                 sat_cnt_valid
);

  logic            acc;
  logic            out_free;
  logic [WSH-1:0]  shift_q;
  logic [WSH-1:0]  shift_use;
  logic [1:0]      mode_q;
  logic [1:0]      mode_use;
  logic [WOUT-1:0] re_y;
  logic [WOUT-1:0] im_y;
  logic            re_sat;
  logic            im_sat;
  logic            skid_v;
  logic            skid_sop;
  logic            skid_eop;
  logic [1:0]      skid_err;
  logic [WOUT-1:0] skid_re;
  logic [WOUT-1:0] skid_im;
  logic            skid_sat;

  assign acc       = sink_valid & sink_ready;
  assign out_free  = ~source_valid | source_ready;
  assign shift_use = (acc & sink_sop) ? shift_in : shift_q;
  assign mode_use  = (acc & sink_sop) ? rnd_mode : mode_q;

  idct_round_sat_lane #(.WIN(WIN), .WOUT(WOUT), .WSH(WSH)) u_re (
    .x(sink_real), .shift(shift_use), .mode(mode_use),
    .y(re_y), .sat(re_sat)
  );

  idct_round_sat_lane #(.WIN(WIN), .WOUT(WOUT), .WSH(WSH)) u_im (
    .x(sink_imag), .shift(shift_use), .mode(mode_use),
    .y(im_y), .sat(im_sat)
  );

  // Frame parameters are captured on every accepted sop beat.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      shift_q <= WSH'(SHIFT_DEF);
      mode_q  <= RND_HALF_UP;
    end else if (acc && sink_sop) begin
      shift_q <= shift_in;
      mode_q  <= rnd_mode;
    end
  end

  // Output register refills from skid first; skid catches a stalled beat.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_error <= '0;
      source_real  <= '0;
      source_imag  <= '0;
      source_sat   <= 1'b0;
      skid_v       <= 1'b0;
      skid_sop     <= 1'b0;
      skid_eop     <= 1'b0;
      skid_err     <= '0;
      skid_re      <= '0;
      skid_im      <= '0;
      skid_sat     <= 1'b0;
      sink_ready   <= 1'b0;
    end else begin
      sink_ready <= out_free ? 1'b1 : ~(skid_v | acc);
      if (out_free) begin
        if (skid_v) begin
          source_valid <= 1'b1;
          source_sop   <= skid_sop;
          source_eop   <= skid_eop;
          source_error <= skid_err;
          source_real  <= skid_re;
          source_imag  <= skid_im;
          source_sat   <= skid_sat;
          skid_v       <= 1'b0;
        end else if (acc) begin
          source_valid <= 1'b1;
          source_sop   <= sink_sop;
          source_eop   <= sink_eop;
          source_error <= sink_error;
          source_real  <= re_y;
          source_imag  <= im_y;
          source_sat   <= re_sat | im_sat;
        end else begin
          source_valid <= 1'b0;
        end
      end else if (acc) begin
        skid_v   <= 1'b1;
        skid_sop <= sink_sop;
        skid_eop <= sink_eop;
        skid_err <= sink_error;
        skid_re  <= re_y;
        skid_im  <= im_y;
        skid_sat <= re_sat | im_sat;
      end
    end
  end

`ifdef IDCT_SAT_CNT_EN
  logic                 xfer;
  logic [SAT_CNT_W-1:0] cnt_q;
  logic [SAT_CNT_W-1:0] cnt_base;
  logic [SAT_CNT_W-1:0] cnt_next;

  assign xfer     = source_valid & source_ready;
  assign cnt_base = source_sop ? '0 : cnt_q;
  assign cnt_next = (source_sat && cnt_base != '1) ?
                    cnt_base + 1'b1 : cnt_base;
  assign sat_cnt  = cnt_q;

  // Count saturated beats as they leave; strobe after the eop beat.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      cnt_q         <= '0;
      sat_cnt_valid <= 1'b0;
    end else begin
      sat_cnt_valid <= xfer & source_eop;
      if (xfer) cnt_q <= cnt_next;
    end
  end
`else
  assign sat_cnt       = '0;
  assign sat_cnt_valid = 1'b0;
`endif

endmodule

// File: tb/tb_idct_round_sat_pipe.sv
// Directed bench for idct_round_sat_pipe (WIN=42, WOUT=24, WSH=5).
// Counter expectations follow IDCT_SAT_CNT_EN when defined.
module tb_idct_round_sat_pipe;

  logic        clk;
  logic        rst_sync;
  logic        sink_valid;
  logic        sink_ready;
  logic        sink_sop;
  logic        sink_eop;
  logic [1:0]  sink_error;
  logic [41:0] sink_real;
  logic [41:0] sink_imag;
  logic [4:0]  shift_in;
  logic [1:0]  rnd_mode;
  logic        source_valid;
  logic        source_ready;
  logic        source_sop;
  logic        source_eop;
  logic [1:0]  source_error;
  logic [23:0] source_real;
  logic [23:0] source_imag;
  logic        source_sat;
  logic [15:0] sat_cnt;
  logic        sat_cnt_valid;

  int checks = 0;
  int errors = 0;
  int n_strobe = 0;

`ifdef IDCT_SAT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  idct_round_sat_pipe dut (
    .clk(clk), .rst_sync(rst_sync),
    .sink_valid(sink_valid), .sink_ready(sink_ready),
    .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_error(sink_error),
    .sink_real(sink_real), .sink_imag(sink_imag),
    .shift_in(shift_in), .rnd_mode(rnd_mode),
    .source_valid(source_valid), .source_ready(source_ready),
    .source_sop(source_sop), .source_eop(source_eop),
    .source_error(source_error),
    .source_real(source_real), .source_imag(source_imag),
    .source_sat(source_sat),
    .sat_cnt(sat_cnt), .sat_cnt_valid(sat_cnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (sat_cnt_valid) n_strobe++;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic sop, input logic eop,
                      input longint re, input longint im,
                      input int sh, input int md);
    sink_valid = 1'b1;
    sink_sop   = sop;
    sink_eop   = eop;
    sink_real  = 42'(re);
    sink_imag  = 42'(im);
    shift_in   = 5'(sh);
    rnd_mode   = 2'(md);
    sink_error = 2'(md);
    @(posedge clk); #1;
    sink_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag,
                            input logic [23:0] er,
                            input logic [23:0] ei,
                            input logic es);
    check({tag, "_vld"}, source_valid, 1);
    check({tag, "_re"}, source_real, er);
    check({tag, "_im"}, source_imag, ei);
    check({tag, "_sat"}, source_sat, es);
  endtask

  initial begin
    longint big;
    longint under;
    logic [23:0] tmp;
    int sent;
    int rcv;
    int cyc;
    bit acc;
    bit saw_full;

    big   = (longint'(8388607) << 16) + 32768;
    under = (longint'(8388607) << 16) + 32767;
    rst_sync = 1'b1; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    sink_error = '0; sink_real = '0; sink_imag = '0;
    shift_in = '0; rnd_mode = '0; source_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", source_valid, 0);
    check("rst_ready", sink_ready, 0);
    check("rst_real", source_real, 0);
    check("rst_sat", source_sat, 0);
    check("rst_cnt", sat_cnt, 0);
    check("rst_strobe", sat_cnt_valid, 0);
    rst_sync = 1'b0;
    @(posedge clk); #1;
    check("rdy_after_rst", sink_ready, 1);

    // Default shift 16 / half-up before any sop.
    beat(0, 0, 163840, 98304, 0, 0);
    expect_out("def", 3, 2, 0);

    beat(1, 0, 98304, 163840, 16, 1);
    expect_out("m1a", 2, 3, 0);
    beat(0, 0, -98304, 0, 16, 1);
    expect_out("m1b", 24'hFFFFFF, 0, 0);

    beat(1, 0, 98304, 163840, 16, 2);
    expect_out("m2a", 2, 2, 0);
    check("err_pass", source_error, 2);
    check("sop_pass", source_sop, 1);
    beat(0, 0, -98304, 0, 16, 2);
    expect_out("m2b", 24'hFFFFFE, 0, 0);

    beat(1, 0, 98304, 163840, 16, 0);
    expect_out("m0a", 1, 2, 0);
    beat(0, 0, -98304, 0, 16, 0);
    expect_out("m0b", 24'hFFFFFE, 0, 0);

    beat(1, 0, 163840, -98304, 16, 3);
    expect_out("m3", 3, 24'hFFFFFF, 0);

    beat(1, 0, big, -(longint'(1) << 40), 16, 1);
    expect_out("sat_hi_lo", 24'h7FFFFF, 24'h800000, 1);
    beat(0, 0, under, -(longint'(1) << 39), 16, 1);
    expect_out("edge_nosat", 24'h7FFFFF, 24'h800000, 0);

    // Mid-frame shift change is ignored until the next sop.
    beat(1, 0, 98304, 0, 16, 1);
    expect_out("midA", 2, 0, 0);
    beat(0, 0, 98304, 0, 0, 0);
    expect_out("midB", 2, 0, 0);
    beat(1, 1, 12345, -777, 0, 2);
    expect_out("sh0", 12345, 24'hFFFCF7, 0);
    check("one_beat_eop", source_eop, 1);
    @(posedge clk); #1;

    // Six-beat stream with output stall in cycles 2-4.
    sent = 0; rcv = 0; cyc = 0; saw_full = 1'b0;
    while (rcv < 6 && cyc < 40) begin
      source_ready = !(cyc >= 2 && cyc <= 4);
      check("str_rdy", sink_ready, (sent - rcv) < 2);
      if (!sink_ready) saw_full = 1'b1;
      if (source_valid && source_ready) begin
        tmp = 24'(-rcv);
        check("str_re", source_real, 24'(rcv));
        check("str_im", source_imag, tmp);
        rcv++;
      end
      acc = 1'b0;
      if (sent < 6) begin
        sink_valid = 1'b1;
        sink_sop   = (sent == 0);
        sink_eop   = (sent == 5);
        sink_real  = 42'(longint'(sent) << 16);
        sink_imag  = 42'(-(longint'(sent) << 16));
        shift_in   = 5'd16;
        rnd_mode   = 2'd0;
        acc = sink_ready;
      end else begin
        sink_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    sink_valid = 1'b0;
    source_ready = 1'b1;
    check("str_all", rcv, 6);
    check("str_full_seen", saw_full, 1);
    @(posedge clk); #1;

    // Four-beat frame, beats 1 and 3 saturate.
    n_strobe = 0;
    beat(1, 0, 65536, 0, 16, 1);
    beat(0, 0, big, 0, 16, 1);
    beat(0, 0, 65536, 0, 16, 1);
    beat(0, 1, 0, -(longint'(1) << 40), 16, 1);
    check("f_eop", source_eop, 1);
    check("f_sat", source_sat, 1);
    @(posedge clk); #1;
    check("cnt_vld", sat_cnt_valid, CNT_EN);
    check("cnt_val", sat_cnt, CNT_EN ? 2 : 0);
    @(posedge clk); #1;
    check("cnt_vld_off", sat_cnt_valid, 0);
    check("cnt_pulses", n_strobe, CNT_EN ? 1 : 0);

    // Reset with two beats buffered discards them.
    n_strobe = 0;
    beat(1, 0, big, 0, 16, 1);
    beat(0, 0, 65536, 0, 16, 1);
    source_ready = 1'b0;
    beat(0, 0, 131072, 0, 16, 1);
    check("pre_rst_full", sink_ready, 0);
    rst_sync = 1'b1;
    @(posedge clk); #1;
    rst_sync = 1'b0;
    check("rst_mid_vld", source_valid, 0);
    check("rst_mid_rdy", sink_ready, 0);
    @(posedge clk); #1;
    check("rst_mid_rdy1", sink_ready, 1);
    source_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_empty", source_valid, 0);
    check("rst_mid_nostrobe", n_strobe, 0);
    beat(1, 1, 65536, 0, 16, 1);
    expect_out("post_rst", 1, 0, 0);
    @(posedge clk); #1;
    check("post_cnt_vld", sat_cnt_valid, CNT_EN);
    check("post_cnt", sat_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
